// File: rtl/mem_pkg.sv
// Shared types and constants for the line-memory port arbiter.
package mem_pkg;

  localparam int LINE_W     = 512;
  localparam int ADDR_W     = 64;
  localparam int LINE_BYTES = 64;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-6){1'b1}}, 6'b0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic                  we;
    logic [LINE_W-1:0]     wdata;
    logic [LINE_BYTES-1:0] wmask;
  } line_req_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the pointer moves away from a port once its grant completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] grant
);

  // ptr = 0 favours port 0 (fetch), ptr = 1 favours port 1 (data)
  logic ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (upd) begin
      ptr <= ~upd_idx;
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-byte-line memory port between the fetch and data requesters,
// one outstanding request per port, round-robin when both are waiting.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int LINE_BITS = 512,
  parameter int ADDR_BITS = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ic_enable,
  input  logic [ADDR_BITS-1:0]   iaddr,
  output logic [LINE_BITS-1:0]   idata,
  output logic                   ic_done,
  input  logic                   dc_enable,
  input  logic [ADDR_BITS-1:0]   daddr,
  input  logic                   dwrite,
  input  logic [LINE_BITS-1:0]   dwdata,
  input  logic [LINE_BITS/8-1:0] dwmask,
  output logic [LINE_BITS-1:0]   ddata,
  output logic                   dc_done,
  output logic                   mem_req,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic                   mem_we,
  output logic [LINE_BITS-1:0]   mem_wdata,
  output logic [LINE_BITS/8-1:0] mem_wmask,
  input  logic [LINE_BITS-1:0]   mem_rdata,
  input  logic                   mem_done,
  output arb_state_t             state
);

  logic                 i_pend;
  logic                 d_pend;
  logic [ADDR_BITS-1:0] i_addr;
  line_req_t            d_req;
  logic                 i_accept;
  logic                 d_accept;
  logic                 i_fin;
  logic                 d_fin;
  logic [1:0]           grant;

  // The pending bit stays set until mem_done, so it also covers "in flight".
  assign i_accept = ic_enable & ~i_pend;
  assign d_accept = dc_enable & ~d_pend;
  assign i_fin    = (state == I_BUSY) & mem_done;
  assign d_fin    = (state == D_BUSY) & mem_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_pend <= 1'b0;
      d_pend <= 1'b0;
      i_addr <= '0;
      d_req  <= '0;
    end else begin
      if (i_accept) begin
        i_pend <= 1'b1;
        i_addr <= iaddr;
      end else if (i_fin) begin
        i_pend <= 1'b0;
      end
      if (d_accept) begin
        d_pend <= 1'b1;
        d_req  <= '{addr: daddr, we: dwrite, wdata: dwdata, wmask: dwmask};
      end else if (d_fin) begin
        d_pend <= 1'b0;
      end
    end
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({d_pend, i_pend}),
    .upd     (i_fin | d_fin),
    .upd_idx (d_fin),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      idata     <= '0;
      ddata     <= '0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant[0]) begin
            state     <= I_BUSY;
            mem_req   <= 1'b1;
            mem_addr  <= line_addr(i_addr);
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
          end else if (grant[1]) begin
            state     <= D_BUSY;
            mem_req   <= 1'b1;
            mem_addr  <= line_addr(d_req.addr);
            mem_we    <= d_req.we;
            mem_wdata <= d_req.wdata;
            mem_wmask <= d_req.wmask;
          end
        end
        I_BUSY: begin
          if (mem_done) begin
            state   <= RESP;
            mem_req <= 1'b0;
            idata   <= mem_rdata;
            ic_done <= 1'b1;
          end
        end
        D_BUSY: begin
          if (mem_done) begin
            state   <= RESP;
            mem_req <= 1'b0;
            ddata   <= d_req.we ? '0 : mem_rdata;
            dc_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ic_done <= 1'b0;
          dc_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int LB = 512;
  localparam int AB = 64;
  localparam int MB = 64;

  localparam logic [LB-1:0] LA = {16{32'h1111_0001}};
  localparam logic [LB-1:0] LBD = {16{32'h2222_0002}};
  localparam logic [LB-1:0] LC = {16{32'h3333_0003}};
  localparam logic [LB-1:0] LD = {16{32'h4444_0004}};
  localparam logic [LB-1:0] LE = {16{32'h5555_0005}};
  localparam logic [LB-1:0] LF = {16{32'h6666_0006}};
  localparam logic [LB-1:0] LG = {16{32'h7777_0007}};
  localparam logic [LB-1:0] LH = {16{32'h8888_0008}};
  localparam logic [LB-1:0] LI = {16{32'h9999_0009}};
  localparam logic [LB-1:0] LJ = {16{32'hAAAA_000A}};
  localparam logic [LB-1:0] WD = {8{64'hDEAD_BEEF_0000_0001}};

  logic          clk;
  logic          reset_n;
  logic          ic_enable;
  logic [AB-1:0] iaddr;
  logic [LB-1:0] idata;
  logic          ic_done;
  logic          dc_enable;
  logic [AB-1:0] daddr;
  logic          dwrite;
  logic [LB-1:0] dwdata;
  logic [MB-1:0] dwmask;
  logic [LB-1:0] ddata;
  logic          dc_done;
  logic          mem_req;
  logic [AB-1:0] mem_addr;
  logic          mem_we;
  logic [LB-1:0] mem_wdata;
  logic [MB-1:0] mem_wmask;
  logic [LB-1:0] mem_rdata;
  logic          mem_done;
  arb_state_t    state;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ic_enable (ic_enable),
    .iaddr     (iaddr),
    .idata     (idata),
    .ic_done   (ic_done),
    .dc_enable (dc_enable),
    .daddr     (daddr),
    .dwrite    (dwrite),
    .dwdata    (dwdata),
    .dwmask    (dwmask),
    .ddata     (ddata),
    .dc_done   (dc_done),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  logic [LB-1:0] exp_q[$];

  typedef struct {
    logic          ic_en;
    logic [AB-1:0] ia;
    logic          dc_en;
    logic [AB-1:0] da;
    logic          dw;
    logic          md;
    logic [LB-1:0] rd;
    logic          e_req;
    logic [AB-1:0] e_addr;
    logic          e_we;
    logic          e_idone;
    logic          e_ddone;
    logic [LB-1:0] e_line;
    arb_state_t    e_state;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ic_en, input logic [AB-1:0] ia, input logic dc_en,
                     input logic [AB-1:0] da, input logic dw, input logic md,
                     input logic [LB-1:0] rd, input logic e_req, input logic [AB-1:0] e_addr,
                     input logic e_we, input logic e_idone, input logic e_ddone,
                     input logic [LB-1:0] e_line, input arb_state_t e_state);
    vec_t v;
    v.ic_en = ic_en; v.ia = ia; v.dc_en = dc_en; v.da = da; v.dw = dw;
    v.md = md; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we;
    v.e_idone = e_idone; v.e_ddone = e_ddone; v.e_line = e_line; v.e_state = e_state;
    vq.push_back(v);
  endtask

  // Zero-wait memory model: answers in every cycle mem_req is seen high.
  task automatic run_until_idone(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      mem_done = mem_req;
      tick();
      if (ic_done) begin
        seen = 1'b1;
        break;
      end
    end
    mem_done = 1'b0;
  endtask

  task automatic check_idone(input string name);
    if (exp_q.size() > 0) chk(name, idata, exp_q.pop_front());
    else chk({name, "_unexpected"}, 1'b1, 1'b0);
  endtask

  initial begin
    bit seen;
    int rises;
    int dones;
    int busy;
    logic prev;

    reset_n = 1'b0; ic_enable = 1'b0; iaddr = '0; dc_enable = 1'b0; daddr = '0;
    dwrite = 1'b0; dwdata = WD; dwmask = 64'hFF; mem_rdata = '0; mem_done = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_idata", idata, 0);
    chk("rst_ddata", ddata, 0);
    chk("rst_ic_done", ic_done, 0);
    chk("rst_dc_done", dc_done, 0);
    chk("rst_state", state, IDLE);
    reset_n = 1'b1;

    // simultaneous pair right after reset: fetch first (mem_done in RESP is ignored)
    add(1, 64'h40, 1, 64'h80, 0, 0, 0,   0, 0, 0, 0, 0, 0, IDLE);
    add(0, 0, 0, 0, 0, 0, 0,             1, 64'h40, 0, 0, 0, 0, I_BUSY);
    add(0, 0, 0, 0, 0, 1, LA,            0, 0, 0, 1, 0, LA, RESP);
    add(0, 0, 0, 0, 0, 1, LF,            0, 0, 0, 0, 0, 0, IDLE);
    add(0, 0, 0, 0, 0, 0, 0,             1, 64'h80, 0, 0, 0, 0, D_BUSY);
    add(0, 0, 0, 0, 0, 1, LBD,           0, 0, 0, 0, 1, LBD, RESP);
    add(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, IDLE);
    // single fetch, two-cycle memory, unaligned address
    add(1, 64'h1234, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, IDLE);
    add(0, 0, 0, 0, 0, 0, 0,             1, 64'h1200, 0, 0, 0, 0, I_BUSY);
    add(0, 0, 0, 0, 0, 0, 0,             1, 64'h1200, 0, 0, 0, 0, I_BUSY);
    add(0, 0, 0, 0, 0, 1, LC,            0, 0, 0, 1, 0, LC, RESP);
    add(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, IDLE);
    // repeat pair after a fetch grant: data first (mem_done in IDLE is ignored)
    add(1, 64'h40, 1, 64'h80, 0, 1, LF,  0, 0, 0, 0, 0, 0, IDLE);
    add(0, 0, 0, 0, 0, 0, 0,             1, 64'h80, 0, 0, 0, 0, D_BUSY);
    add(0, 0, 0, 0, 0, 1, LD,            0, 0, 0, 0, 1, LD, RESP);
    add(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, IDLE);
    add(0, 0, 0, 0, 0, 0, 0,             1, 64'h40, 0, 0, 0, 0, I_BUSY);
    add(0, 0, 0, 0, 0, 1, LE,            0, 0, 0, 1, 0, LE, RESP);
    add(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, IDLE);
    // data write: ddata must read back 0 even though mem_rdata is non-zero
    add(0, 0, 1, 64'h1000, 1, 0, 0,      0, 0, 0, 0, 0, 0, IDLE);
    add(0, 0, 0, 0, 0, 0, 0,             1, 64'h1000, 1, 0, 0, 0, D_BUSY);
    add(0, 0, 0, 0, 0, 1, LF,            0, 0, 0, 0, 1, 0, RESP);
    add(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, IDLE);

    @(posedge clk);
    #1;
    foreach (vq[i]) begin
      ic_enable = vq[i].ic_en; iaddr = vq[i].ia;
      dc_enable = vq[i].dc_en; daddr = vq[i].da; dwrite = vq[i].dw;
      mem_done = vq[i].md; mem_rdata = vq[i].rd;
      tick();
      chk($sformatf("v%0d_mem_req", i), mem_req, vq[i].e_req);
      chk($sformatf("v%0d_state", i), state, vq[i].e_state);
      chk($sformatf("v%0d_ic_done", i), ic_done, vq[i].e_idone);
      chk($sformatf("v%0d_dc_done", i), dc_done, vq[i].e_ddone);
      if (vq[i].e_req) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vq[i].e_addr);
        chk($sformatf("v%0d_mem_we", i), mem_we, vq[i].e_we);
      end
      if (vq[i].e_we) begin
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, WD);
        chk($sformatf("v%0d_mem_wmask", i), mem_wmask, 64'hFF);
      end
      if (vq[i].e_idone) chk($sformatf("v%0d_idata", i), idata, vq[i].e_line);
      if (vq[i].e_ddone) chk($sformatf("v%0d_ddata", i), ddata, vq[i].e_line);
    end
    ic_enable = 1'b0; dc_enable = 1'b0; dwrite = 1'b0; mem_done = 1'b0;

    // duplicate enable held 5 cycles while the fetch is in flight
    iaddr = 64'h2000; mem_rdata = LG; exp_q.push_back(LG);
    rises = 0; dones = 0; busy = 0; prev = mem_req;
    for (int i = 0; i < 24; i++) begin
      ic_enable = (i < 5);
      mem_done = mem_req && (busy >= 5);
      tick();
      if (mem_req && !prev) rises++;
      prev = mem_req;
      busy = mem_req ? busy + 1 : 0;
      if (ic_done) begin
        dones++;
        check_idone("dup_idata");
      end
    end
    ic_enable = 1'b0; mem_done = 1'b0;
    chk("dup_req_count", rises, 1);
    chk("dup_done_count", dones, 1);

    // back-to-back: re-enable in the ic_done cycle
    iaddr = 64'h3000; mem_rdata = LH; exp_q.push_back(LH);
    ic_enable = 1'b1;
    tick();
    ic_enable = 1'b0;
    run_until_idone(10, seen);
    chk("b2b_first_done_seen", seen, 1);
    if (seen) check_idone("b2b_first_idata");
    iaddr = 64'h3047; mem_rdata = LI; ic_enable = 1'b1;
    tick();
    ic_enable = 1'b0;
    chk("b2b_accept_req_low", mem_req, 0);
    tick();
    chk("b2b_second_req", mem_req, 1);
    chk("b2b_second_addr", mem_addr, 64'h3040);
    exp_q.push_back(LI);
    run_until_idone(10, seen);
    chk("b2b_second_done_seen", seen, 1);
    if (seen) check_idone("b2b_second_idata");
    tick();

    // reset asserted while the fetch is in I_BUSY
    iaddr = 64'h4000; ic_enable = 1'b1;
    tick();
    ic_enable = 1'b0;
    tick();
    chk("rb_req_before", mem_req, 1);
    chk("rb_state_before", state, I_BUSY);
    #2 reset_n = 1'b0;
    #1;
    chk("rb_req_async_drop", mem_req, 0);
    chk("rb_state_idle", state, IDLE);
    @(posedge clk);
    #3 reset_n = 1'b1;
    dones = 0;
    mem_done = 1'b1; mem_rdata = LF;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_done = 1'b0;
      if (ic_done || mem_req) dones++;
    end
    chk("rb_no_done_or_req", dones, 0);
    iaddr = 64'h5010; mem_rdata = LJ; exp_q.push_back(LJ);
    ic_enable = 1'b1;
    tick();
    ic_enable = 1'b0;
    tick();
    chk("rb_next_req", mem_req, 1);
    chk("rb_next_addr", mem_addr, 64'h5000);
    run_until_idone(10, seen);
    chk("rb_next_done_seen", seen, 1);
    if (seen) check_idone("rb_next_idata");
    tick();
    chk("final_state_idle", state, IDLE);
    chk("final_exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
